// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-stream packet demux family.
// The beat record depends on the data/select widths, so each module that
// needs it declares it locally from its own DW/SW parameters.
package axis_pkg;

  // Input-side packet tracking state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  localparam int DROP_CNT_W = 32;

endpackage

// File: rtl/axis_skid2.sv
// Generic 2-entry skid buffer with a registered ready.
// The main entry is the head presented downstream. The skid entry catches
// the one beat that can arrive after the head stalls. Ready is a flop, so
// the downstream ready never reaches the upstream ready combinationally.
module axis_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic             rdy_q;
  logic             push, pop;

  assign push = in_valid_i & rdy_q;
  assign pop  = main_vld_q & out_ready_i;

  // Next-state for both entries; skid only fills while the head is stuck
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || pop) begin
      if (skid_vld_q) begin
        // ready was low, so no push can coincide with a skid refill
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        if (push) main_d = in_data_i;
        main_vld_d = push;
      end
    end else if (push) begin
      skid_d     = in_data_i;
      skid_vld_d = 1'b1;
    end
  end

  // Entry registers; data cleared on reset so outputs never carry X
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= ~skid_vld_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_data_o  = main_q;
  assign out_valid_o = main_vld_q;

endmodule

// File: rtl/axis_pkt_demux.sv
// Packet-aware 1-to-NOUT AXI-stream demux.
// Destination is sampled on the first beat of a packet and held until tlast,
// so a packet never splits across outputs. Beats addressed beyond NOUT are
// popped without handshake and counted per packet. NOUT must not exceed 2**SW.
module axis_pkt_demux
  import axis_pkg::*;
#(
  parameter int DW   = 512,
  parameter int NOUT = 4,
  parameter int SW   = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [SW-1:0]         port_select,
  input  logic [DW-1:0]         axis_in_tdata,
  input  logic                  axis_in_tlast,
  input  logic                  axis_in_tvalid,
  output logic                  axis_in_tready,
  output logic [DW-1:0]         axis_out_tdata,
  output logic                  axis_out_tlast,
  output logic [NOUT-1:0]       axis_out_tvalid,
  input  logic [NOUT-1:0]       axis_out_tready,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  busy
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [SW-1:0] dest;
  } beat_t;

  state_e                state_q, state_d;
  logic [SW-1:0]         dest_q, dest_d;
  logic [SW-1:0]         in_dest;
  logic                  accept;
  beat_t                 in_beat, head;
  logic                  head_vld, head_ready;
  logic [NOUT-1:0]       hit;
  logic                  dest_ok;
  logic [DROP_CNT_W-1:0] drop_q;

  assign accept = axis_in_tvalid & axis_in_tready;

  // Packet state and latched destination
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  // Advance on accepted beats only; tlast always closes the packet
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    if (accept) begin
      state_d = axis_in_tlast ? ST_IDLE : ST_PKT;
      if (state_q == ST_IDLE) dest_d = port_select;
    end
  end

  // First beat uses the live select; later beats use the latched one
  always_comb begin
    in_dest = dest_q;
    if (state_q == ST_IDLE) in_dest = port_select;
  end

  assign in_beat = '{data: axis_in_tdata, last: axis_in_tlast, dest: in_dest};

  axis_skid2 #(
    .WIDTH ($bits(beat_t))
  ) u_skid (
    .clk         (clk),
    .resetn      (resetn),
    .in_data_i   (in_beat),
    .in_valid_i  (axis_in_tvalid),
    .in_ready_o  (axis_in_tready),
    .out_data_o  (head),
    .out_valid_o (head_vld),
    .out_ready_i (head_ready)
  );

  // One-hot destination decode and per-output valid fan-out
  for (genvar i = 0; i < NOUT; i++) begin : g_out
    assign hit[i]             = (head.dest == SW'(i));
    assign axis_out_tvalid[i] = head_vld & hit[i];
  end

  // Dest outside the populated range: drain the head every cycle
  assign dest_ok    = |hit;
  assign head_ready = dest_ok ? |(hit & axis_out_tready) : 1'b1;

  // Count dropped packets on their final beat; wraps naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                               drop_q <= '0;
    else if (head_vld && !dest_ok && head.last) drop_q <= drop_q + DROP_CNT_W'(1);
  end

  assign axis_out_tdata = head.data;
  assign axis_out_tlast = head.last;
  assign drop_count     = drop_q;
  assign busy           = (state_q == ST_PKT) | head_vld;

endmodule

// File: tb/tb_axis_pkt_demux.sv
// Scoreboard bench: stimulus pushes hand-computed expected beats, a negedge
// monitor compares every presented beat and pops on handshake.
// A second instance with NOUT=3 exercises the drop path.
module tb_axis_pkt_demux;

  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        v4 = 1'b0, v3 = 1'b0;
  logic [3:0]  tready4 = 4'hF;
  logic [2:0]  tready3 = 3'b000;

  logic        rdy4, olast4, busy4, rdy3, olast3, busy3;
  logic [31:0] odata4, odata3, drop4, drop3;
  logic [3:0]  ovld4;
  logic [2:0]  ovld3;

  always #5 clk = ~clk;

  axis_pkt_demux #(.DW(DW), .NOUT(4), .SW(2)) dut4 (
    .clk(clk), .resetn(resetn), .port_select(sel),
    .axis_in_tdata(tdata), .axis_in_tlast(tlast), .axis_in_tvalid(v4),
    .axis_in_tready(rdy4), .axis_out_tdata(odata4), .axis_out_tlast(olast4),
    .axis_out_tvalid(ovld4), .axis_out_tready(tready4),
    .drop_count(drop4), .busy(busy4));

  axis_pkt_demux #(.DW(DW), .NOUT(3), .SW(2)) dut3 (
    .clk(clk), .resetn(resetn), .port_select(sel),
    .axis_in_tdata(tdata), .axis_in_tlast(tlast), .axis_in_tvalid(v3),
    .axis_in_tready(rdy3), .axis_out_tdata(odata3), .axis_out_tlast(olast3),
    .axis_out_tvalid(ovld3), .axis_out_tready(tready3),
    .drop_count(drop3), .busy(busy3));

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic [3:0] ev;
  int checks = 0, errors = 0;
  int cyc = 0;
  int t_rel, t_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare presented beat with scoreboard head, pop on handshake
  always @(negedge clk) begin
    if (resetn && ovld4 != 4'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", {60'b0, ovld4}, 64'd0);
      end else begin
        e  = q[0];
        ev = 4'b0001 << e.port;
        chk("route", {60'b0, ovld4}, {60'b0, ev});
        chk("data", {32'b0, odata4}, {32'b0, e.data});
        chk("last", {63'b0, olast4}, {63'b0, e.last});
        if ((ovld4 & tready4) != 4'b0) void'(q.pop_front());
      end
    end
  end

  // Present one beat to dut4 and record its expected output port
  task automatic send(input logic [31:0] d, input logic l, input logic [1:0] s, input int port);
    int n = 0;
    tdata = d; tlast = l; sel = s; v4 = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy4) begin
        q.push_back('{port, d, l});
        @(posedge clk); #1;
        v4 = 1'b0;
        return;
      end
      n++;
      if (n > 50) begin
        chk("accept_timeout", 64'd0, 64'd1);
        v4 = 1'b0;
        return;
      end
    end
  endtask

  // Present one beat to dut3; it must never stall and never assert tvalid
  task automatic send3(input logic [31:0] d, input logic l, input logic [1:0] s);
    tdata = d; tlast = l; sel = s; v3 = 1'b1;
    @(negedge clk);
    chk("drop_in_ready", {63'b0, rdy3}, 64'd1);
    chk("drop_no_vld", {61'b0, ovld3}, 64'd0);
    @(posedge clk); #1;
    v3 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    #2;
    chk("rst_in_ready", {63'b0, rdy4}, 64'd0);
    chk("rst_vld", {60'b0, ovld4}, 64'd0);
    chk("rst_drop", drop4, 64'd0);
    chk("rst_busy", {63'b0, busy4}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    chk("rdy_before_edge", {63'b0, rdy4}, 64'd0);
    @(posedge clk); #1;
    chk("rdy_after_edge", {63'b0, rdy4}, 64'd1);

    // Basic routing, 3 beats to port 2, one cycle latency
    send(32'hA000_0000, 1'b0, 2'd2, 2);
    chk("latency_vld", {60'b0, ovld4}, 64'h4);
    chk("busy_in_pkt", {63'b0, busy4}, 64'd1);
    send(32'hA000_0001, 1'b0, 2'd2, 2);
    send(32'hA000_0002, 1'b1, 2'd2, 2);
    drain();
    chk("idle_busy", {63'b0, busy4}, 64'd0);

    // Select changes mid-packet; packet stays on port 1
    send(32'hB000_0000, 1'b0, 2'd1, 1);
    send(32'hB000_0001, 1'b0, 2'd3, 1);
    send(32'hB000_0002, 1'b0, 2'd3, 1);
    send(32'hB000_0003, 1'b1, 2'd3, 1);
    send(32'hB000_0004, 1'b0, 2'd3, 3);
    send(32'hB000_0005, 1'b1, 2'd3, 3);
    drain();

    // Backpressure on port 0 for 5 clocks during an 8-beat packet
    tready4 = 4'b1110;
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'hC000_0000 + 32'(i), (i == 7), 2'd0, 0);
        t_done = cyc;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_in_ready_low", {63'b0, rdy4}, 64'd0);
        t_rel = cyc;
        tready4 = 4'hF;
      end
    join
    chk("bp_throughput", {63'b0, ((t_done - t_rel) <= 7)}, 64'd1);
    drain();

    // Drop path on NOUT=3: two packets to port 3, readies all low
    send3(32'hD000_0000, 1'b1, 2'd3);
    send3(32'hD000_0001, 1'b0, 2'd3);
    send3(32'hD000_0002, 1'b0, 2'd3);
    send3(32'hD000_0003, 1'b0, 2'd3);
    send3(32'hD000_0004, 1'b1, 2'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("drop_count", drop3, 64'd2);
    chk("drop_idle_vld", {61'b0, ovld3}, 64'd0);
    chk("drop_idle_busy", {63'b0, busy3}, 64'd0);
    chk("no_drop_on_4", drop4, 64'd0);

    // Per-port isolation: port 1 stalled while others ready
    tready4 = 4'b1101;
    send(32'hE000_0000, 1'b1, 2'd1, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("iso_vld", {60'b0, ovld4}, 64'h2);
    chk("iso_busy", {63'b0, busy4}, 64'd1);
    tready4 = 4'hF;
    drain();

    // Reset in the middle of a 5-beat packet
    tready4 = 4'b0000;
    send(32'hF000_0000, 1'b0, 2'd2, 2);
    tdata = 32'hF000_0001; tlast = 1'b0; v4 = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_vld", {60'b0, ovld4}, 64'd0);
    chk("mid_rst_drop3", drop3, 64'd0);
    chk("mid_rst_rdy", {63'b0, rdy4}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy4}, 64'd0);
    v4 = 1'b0;
    tready4 = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    send(32'h1234_5678, 1'b1, 2'd0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
